spi_adc_responder: RTL and testbench
====================================

Name: spi_adc_responder

Overview:
- SPI mode-0 slave that emulates the board ADC at the far end of the Nios II SPI master link.
- Receives SCLK/SS_n/MOSI from the master and returns per-channel 12-bit samples on MISO.
- Uses a pipelined channel select: the command in frame N selects the channel returned in frame N+1.
- Used for hardware-in-loop bring-up and simulation of the acquisition path without the physical ADC.

Parameters:
- FRAME_BITS, 16, bits per SPI frame (must be >= CH_W+DATA_W+1)
- DATA_W, 12, sample width
- CH_W, 3, channel-select width (2**CH_W channels)
- SYNC_STAGES, 2, synchronizer depth on SCLK/SS_n/MOSI (>= 2)

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  asynchronous active-low reset
- spi_sclk  in  1  SPI clock from master, CPOL=0
- spi_ss_n  in  1  slave select, active low
- spi_mosi  in  1  master-out data
- spi_miso  out  1  slave-out data, MSB first
- spi_miso_oe  out  1  MISO output enable (high while selected)
- sample_data  in  (2**CH_W)*DATA_W  flattened samples; channel k at [k*DATA_W +: DATA_W]
- rx_data  out  FRAME_BITS  last complete command word
- rx_valid  out  1  one-cycle pulse when rx_data updates
- frame_error  out  1  one-cycle pulse on aborted frame
- busy  out  1  high while a frame is in progress
- cur_channel  out  CH_W  channel that the next frame returns

Behaviour:
- Clock and reset: one clock, clk_clk. Reset is reset_reset_n, asynchronous active-low.
- Reset values:
  - spi_miso=0, spi_miso_oe=0, rx_data=0, rx_valid=0, frame_error=0, busy=0, cur_channel=0.
  - Synchronizer flops reset to the idle pattern: sclk=0, ss_n=1, mosi=0.
- Input conditioning:
  - All three SPI inputs pass through SYNC_STAGES flops.
  - Edge detect uses one more flop, so latency from pin to edge event is SYNC_STAGES+1 clk.
  - The master SCLK half-period must be >= SYNC_STAGES+3 clk.
- State machine (IDLE, SHIFT, WAIT_DESELECT):
  - IDLE: on the synchronized ss_n falling edge:
    - Latch tx_shift = {cur_channel, sample_data[cur_channel], zero pad} (MSB at FRAME_BITS-1).
    - Clear bit_cnt; set busy=1 and spi_miso_oe=1.
    - Drive spi_miso = tx_shift MSB in the same cycle the state becomes SHIFT.
  - SHIFT, sclk rising edge: rx_shift = {rx_shift[FRAME_BITS-2:0], mosi}; bit_cnt++.
    - When bit_cnt reaches FRAME_BITS: rx_data<=rx_shift (incl. this bit), rx_valid=1 for one cycle, cur_channel<=new word[FRAME_BITS-1 -: CH_W], go to WAIT_DESELECT.
  - SHIFT, sclk falling edge: tx_shift shifts left with 0 fill; spi_miso = new MSB.
  - SHIFT, ss_n rising before FRAME_BITS rising edges (abort):
    - frame_error=1 for one cycle; rx_data and cur_channel unchanged.
    - Go to IDLE; busy=0, spi_miso_oe=0, spi_miso=0.
  - WAIT_DESELECT:
    - Extra SCLK edges are ignored; spi_miso held 0.
    - On ss_n rising: go to IDLE, busy=0, spi_miso_oe=0.
- Simultaneous events:
  - If ss_n rises in the same cycle as the final rising edge, the frame completes (rx_valid=1, not frame_error); go to IDLE.
  - SCLK edges while in IDLE are ignored.
- Sample capture: sample_data is sampled only at frame start. Changes during a frame do not affect MISO.
- Reset mid-frame: immediate return to reset values; the next frame starts only on a fresh ss_n falling edge after reset deasserts.
- Reset with ss_n held low: no frame starts until ss_n goes high, then low again.
- cur_channel takes all CH_W bits; all 2**CH_W values are valid (wrap-free).

Test Plan:
- Reset, ch0 sample=0xABC, ss_n low, 16 clocks MOSI=0x0000 (SCLK half-period 8 clk) -> MISO word 0x1578 ({000, ABC, 0}); rx_valid once; rx_data=0x0000; cur_channel=0.
- Frame 1 MOSI=0xA000 (ch5), ch5 sample=0x123; frame 2 -> frame 2 MISO=0xA246; frame 1 rx_data=0xA000; cur_channel=5 after frame 1.
- ss_n rises after 9 SCLK rising edges -> frame_error pulse; rx_valid never asserts; cur_channel unchanged; miso_oe=0 within SYNC_STAGES+2 clk of the rise.
- 20 SCLK pulses within one ss_n low window -> exactly one rx_valid; MISO=0 for bits 17-20; busy held until ss_n high.
- sample_data ch0 changed from 0x111 to 0xFFF mid-frame -> MISO still returns 0x111 in that frame and 0xFFF in the next.
- reset_reset_n asserted at bit 7 -> all outputs at reset values asynchronously; a new full frame afterwards is received correctly.

Source files
------------

// File: rtl/spi_adc_responder.sv
// ---------------------------------------------------------------------------
// spi_adc_responder
//
// SPI mode-0 (CPOL=0, CPHA=0) slave that stands in for the board ADC at the
// far end of the Nios II SPI master link.  Each frame returns
// {channel, sample, zero pad} MSB first on MISO while the command shifted
// in on MOSI selects the channel returned by the *next* frame.
//
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   spi_sclk       SPI clock from master (idle low)
//   spi_ss_n       slave select, active low
//   spi_mosi       master-out data
//   spi_miso       slave-out data, MSB first
//   spi_miso_oe    MISO output enable, high while selected
//   sample_data    flattened samples, channel k at [k*DATA_W +: DATA_W]
//   rx_data        last complete command word
//   rx_valid       one-cycle pulse when rx_data updates
//   frame_error    one-cycle pulse when a frame is aborted
//   busy           high while a frame is in progress
//   cur_channel    channel returned by the next frame
// ---------------------------------------------------------------------------
module spi_adc_responder #(
    parameter int FRAME_BITS  = 16,
    parameter int DATA_W      = 12,
    parameter int CH_W        = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic                           clk_clk,
    input  logic                           reset_reset_n,
    input  logic                           spi_sclk,
    input  logic                           spi_ss_n,
    input  logic                           spi_mosi,
    output logic                           spi_miso,
    output logic                           spi_miso_oe,
    input  logic [(2**CH_W)*DATA_W-1:0]    sample_data,
    output logic [FRAME_BITS-1:0]          rx_data,
    output logic                           rx_valid,
    output logic                           frame_error,
    output logic                           busy,
    output logic [CH_W-1:0]                cur_channel
);

    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam int PAD_W = FRAME_BITS - CH_W - DATA_W;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WAIT_DESELECT
    } state_t;

    state_t state, state_n;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] flush;
    logic                   sclk_d;
    logic                   ss_d;
    logic                   armed;

    logic sclk_s, ss_s, mosi_s;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    logic [FRAME_BITS-2:0]  tx_shift;
    logic [FRAME_BITS-2:0]  rx_shift;
    logic [CNT_W-1:0]       bit_cnt;
    logic [DATA_W-1:0]      sample_sel;
    logic [FRAME_BITS-1:0]  tx_word;
    logic [FRAME_BITS-1:0]  rx_word;
    logic                   last_bit;

    logic start_frame, shift_in, shift_out, frame_done, abort, deselect;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign sclk_rise =  sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s &  sclk_d;
    assign ss_rise   =  ss_s   & ~ss_d;
    assign ss_fall   = ~ss_s   &  ss_d;

    assign sample_sel = sample_data[cur_channel*DATA_W +: DATA_W];
    assign tx_word    = {cur_channel, sample_sel, {PAD_W{1'b0}}};
    assign rx_word    = {rx_shift, mosi_s};
    assign last_bit   = (bit_cnt == CNT_W'(FRAME_BITS - 1));

    // Input synchronizers plus one edge-detect flop per control line.
    // The chains reset to the idle bus pattern, so a select that is already
    // low when reset releases would look like a falling edge.  'flush' marks
    // when the chain holds genuine pin samples, and 'armed' only rises once
    // ss_n has really been seen high, so that case never starts a frame.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            mosi_sync <= '0;
            sclk_d    <= 1'b0;
            ss_d      <= 1'b1;
            flush     <= '0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sclk_d    <= sclk_s;
            ss_d      <= ss_s;
            flush     <= {flush[SYNC_STAGES-2:0], 1'b1};
            armed     <= armed | (flush[SYNC_STAGES-1] & ss_s);
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode.  In SHIFT the final rising edge wins over a
    // simultaneous deselect so a frame that just completed is never flagged
    // as aborted.
    always_comb begin
        state_n     = state;
        start_frame = 1'b0;
        shift_in    = 1'b0;
        shift_out   = 1'b0;
        frame_done  = 1'b0;
        abort       = 1'b0;
        deselect    = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall && armed) begin
                    start_frame = 1'b1;
                    state_n     = SHIFT;
                end
            end
            SHIFT: begin
                if (sclk_rise && last_bit) begin
                    frame_done = 1'b1;
                    deselect   = ss_rise;
                    state_n    = ss_rise ? IDLE : WAIT_DESELECT;
                end else if (ss_rise) begin
                    abort   = 1'b1;
                    state_n = IDLE;
                end else if (sclk_rise) begin
                    shift_in = 1'b1;
                end else if (sclk_fall) begin
                    shift_out = 1'b1;
                end
            end
            WAIT_DESELECT: begin
                if (ss_rise) begin
                    deselect = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Frame datapath.  tx_shift holds only the bits not yet on MISO; the
    // current bit lives in the spi_miso flop itself, which is loaded with the
    // MSB on the same edge that enters SHIFT.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;
            busy        <= 1'b0;
            cur_channel <= '0;
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
        end else begin
            rx_valid    <= 1'b0;
            frame_error <= 1'b0;

            if (start_frame) begin
                tx_shift    <= tx_word[FRAME_BITS-2:0];
                spi_miso    <= tx_word[FRAME_BITS-1];
                rx_shift    <= '0;
                bit_cnt     <= '0;
                busy        <= 1'b1;
                spi_miso_oe <= 1'b1;
            end

            if (shift_in) begin
                rx_shift <= rx_word[FRAME_BITS-2:0];
                bit_cnt  <= bit_cnt + CNT_W'(1);
            end

            if (shift_out) begin
                spi_miso <= tx_shift[FRAME_BITS-2];
                tx_shift <= {tx_shift[FRAME_BITS-3:0], 1'b0};
            end

            // Command of this frame picks the channel for the next one.
            if (frame_done) begin
                rx_data     <= rx_word;
                rx_valid    <= 1'b1;
                cur_channel <= rx_word[FRAME_BITS-1 -: CH_W];
                bit_cnt     <= bit_cnt + CNT_W'(1);
                spi_miso    <= 1'b0;
            end

            if (abort) begin
                frame_error <= 1'b1;
            end

            if (abort || deselect) begin
                busy        <= 1'b0;
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_adc_responder.sv
// ---------------------------------------------------------------------------
// tb_spi_adc_responder
//
// Drives the responder as a mode-0 SPI master with an 8-clock SCLK
// half-period.  Complete command words are queued as they are sent and
// matched against rx_data whenever rx_valid pulses; MISO words and the
// selected channel are compared against a table of hand-derived frames,
// followed by abort, over-length, mid-frame sample change and mid-frame
// reset sequences.
// ---------------------------------------------------------------------------
module tb_spi_adc_responder;

    localparam int FB   = 16;
    localparam int DW   = 12;
    localparam int CW   = 3;
    localparam int HALF = 8;

    typedef struct {
        logic [FB-1:0] mosi;
        logic [FB-1:0] exp_miso;
        logic [CW-1:0] exp_ch;
    } vec_t;

    logic                    clk;
    logic                    reset_n;
    logic                    spi_sclk;
    logic                    spi_ss_n;
    logic                    spi_mosi;
    logic                    spi_miso;
    logic                    spi_miso_oe;
    logic [(2**CW)*DW-1:0]   sample_data;
    logic [FB-1:0]           rx_data;
    logic                    rx_valid;
    logic                    frame_error;
    logic                    busy;
    logic [CW-1:0]           cur_channel;

    int checks = 0;
    int errors = 0;
    int rv_count = 0;
    int fe_count = 0;
    logic [FB-1:0] exp_q[$];

    vec_t vecs[6];

    spi_adc_responder #(
        .FRAME_BITS (FB),
        .DATA_W     (DW),
        .CH_W       (CW),
        .SYNC_STAGES(2)
    ) dut (
        .clk_clk      (clk),
        .reset_reset_n(reset_n),
        .spi_sclk     (spi_sclk),
        .spi_ss_n     (spi_ss_n),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .sample_data  (sample_data),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .frame_error  (frame_error),
        .busy         (busy),
        .cur_channel  (cur_channel)
    );

    // 100 MHz system clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One master transaction: n_rise SCLK pulses inside one select window.
    // MISO is sampled at each rising SCLK edge; bits past the 16th land in
    // extra_bits.  Ends with ss_n just raised so callers can time deselect.
    task automatic applyStimulus(input logic [FB-1:0] word, input int n_rise,
                                 output logic [FB-1:0] miso_word, output logic [7:0] extra_bits,
                                 output logic busy_pre, output logic oe_pre);
        miso_word  = '0;
        extra_bits = '0;
        @(negedge clk);
        spi_ss_n = 1'b0;
        for (int i = 0; i < n_rise; i++) begin
            spi_mosi = (i < FB) ? word[FB-1-i] : 1'b0;
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b1;
            if (i < FB) miso_word = {miso_word[FB-2:0], spi_miso};
            else        extra_bits = {extra_bits[6:0], spi_miso};
            repeat (HALF) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        busy_pre = busy;
        oe_pre   = spi_miso_oe;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
    endtask

    // Scoreboard side: each rx_valid pulse consumes the oldest queued command
    always @(negedge clk) begin
        if (rx_valid) begin
            rv_count++;
            if (exp_q.size() == 0) begin
                checkOutput("rx_valid_unexpected", 32'd1, 32'd0);
            end else begin
                checkOutput("rx_data", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        if (frame_error) fe_count++;
    end

    initial begin
        logic [FB-1:0] miso_w;
        logic [7:0]    extra;
        logic          busy_pre, oe_pre;
        int            rv0, fe0;
        logic [CW-1:0] model_ch;

        vecs[0] = '{mosi: 16'h0000, exp_miso: 16'h1578, exp_ch: 3'd0};
        vecs[1] = '{mosi: 16'hA000, exp_miso: 16'h1578, exp_ch: 3'd5};
        vecs[2] = '{mosi: 16'h0000, exp_miso: 16'hA246, exp_ch: 3'd0};
        vecs[3] = '{mosi: 16'h6000, exp_miso: 16'h1578, exp_ch: 3'd3};
        vecs[4] = '{mosi: 16'hE000, exp_miso: 16'h6B4A, exp_ch: 3'd7};
        vecs[5] = '{mosi: 16'h2ABC, exp_miso: 16'hFFFE, exp_ch: 3'd1};

        reset_n  = 1'b0;
        spi_sclk = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        sample_data[0*DW +: DW] = 12'hABC;
        sample_data[1*DW +: DW] = 12'h000;
        sample_data[2*DW +: DW] = 12'h321;
        sample_data[3*DW +: DW] = 12'h5A5;
        sample_data[4*DW +: DW] = 12'h0F0;
        sample_data[5*DW +: DW] = 12'h123;
        sample_data[6*DW +: DW] = 12'h777;
        sample_data[7*DW +: DW] = 12'hFFF;

        #22;
        checkOutput("reset_miso", 32'(spi_miso), 32'd0);
        checkOutput("reset_oe", 32'(spi_miso_oe), 32'd0);
        checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_frame_error", 32'(frame_error), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_cur_channel", 32'(cur_channel), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            exp_q.push_back(vecs[v].mosi);
            rv0 = rv_count;
            applyStimulus(vecs[v].mosi, FB, miso_w, extra, busy_pre, oe_pre);
            repeat (2 * HALF) @(negedge clk);
            checkOutput($sformatf("vec%0d_miso", v), 32'(miso_w), 32'(vecs[v].exp_miso));
            checkOutput($sformatf("vec%0d_cur_channel", v), 32'(cur_channel), 32'(vecs[v].exp_ch));
            checkOutput($sformatf("vec%0d_rx_valid_count", v), 32'(rv_count - rv0), 32'd1);
            checkOutput($sformatf("vec%0d_busy_pre", v), 32'(busy_pre), 32'd1);
            checkOutput($sformatf("vec%0d_busy_after", v), 32'(busy), 32'd0);
        end
        model_ch = vecs[5].exp_ch;

        // Abort after 9 rising edges: error pulse, channel kept, OE drops fast
        rv0 = rv_count;
        fe0 = fe_count;
        applyStimulus(16'hC000, 9, miso_w, extra, busy_pre, oe_pre);
        checkOutput("abort_oe_pre", 32'(oe_pre), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("abort_oe_off", 32'(spi_miso_oe), 32'd0);
        checkOutput("abort_busy_off", 32'(busy), 32'd0);
        repeat (2 * HALF) @(negedge clk);
        checkOutput("abort_frame_error_count", 32'(fe_count - fe0), 32'd1);
        checkOutput("abort_rx_valid_count", 32'(rv_count - rv0), 32'd0);
        checkOutput("abort_cur_channel", 32'(cur_channel), 32'(model_ch));
        checkOutput("abort_rx_data_kept", 32'(rx_data), 32'h2ABC);

        // 20 SCLK pulses in one select window
        exp_q.push_back(16'h0000);
        rv0 = rv_count;
        applyStimulus(16'h0000, 20, miso_w, extra, busy_pre, oe_pre);
        repeat (2 * HALF) @(negedge clk);
        checkOutput("long_miso", 32'(miso_w), 32'h2000);
        checkOutput("long_extra_bits", 32'(extra), 32'h00);
        checkOutput("long_busy_held", 32'(busy_pre), 32'd1);
        checkOutput("long_rx_valid_count", 32'(rv_count - rv0), 32'd1);
        checkOutput("long_cur_channel", 32'(cur_channel), 32'd0);

        // Sample changed mid-frame: frame keeps the value captured at start
        sample_data[0*DW +: DW] = 12'h111;
        exp_q.push_back(16'h1234);
        fork
            applyStimulus(16'h1234, FB, miso_w, extra, busy_pre, oe_pre);
            begin
                repeat (100) @(negedge clk);
                sample_data[0*DW +: DW] = 12'hFFF;
            end
        join
        repeat (2 * HALF) @(negedge clk);
        checkOutput("sample_hold_miso", 32'(miso_w), 32'h0222);
        exp_q.push_back(16'h8F0F);
        applyStimulus(16'h8F0F, FB, miso_w, extra, busy_pre, oe_pre);
        repeat (2 * HALF) @(negedge clk);
        checkOutput("sample_next_miso", 32'(miso_w), 32'h1FFE);
        checkOutput("sample_next_cur_channel", 32'(cur_channel), 32'd4);

        // Asynchronous reset near bit 7, released while ss_n is still low
        rv0 = rv_count;
        fe0 = fe_count;
        fork
            applyStimulus(16'h5555, FB, miso_w, extra, busy_pre, oe_pre);
            begin
                repeat (7 * 2 * HALF + 4) @(negedge clk);
                #2 reset_n = 1'b0;
                #1;
                checkOutput("midreset_miso", 32'(spi_miso), 32'd0);
                checkOutput("midreset_oe", 32'(spi_miso_oe), 32'd0);
                checkOutput("midreset_rx_data", 32'(rx_data), 32'd0);
                checkOutput("midreset_busy", 32'(busy), 32'd0);
                checkOutput("midreset_cur_channel", 32'(cur_channel), 32'd0);
                checkOutput("midreset_frame_error", 32'(frame_error), 32'd0);
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                repeat (4 * HALF) @(negedge clk);
                checkOutput("postreset_ss_low_busy", 32'(busy), 32'd0);
            end
        join
        repeat (2 * HALF) @(negedge clk);
        checkOutput("postreset_rx_valid_count", 32'(rv_count - rv0), 32'd0);
        checkOutput("postreset_frame_error_count", 32'(fe_count - fe0), 32'd0);

        exp_q.push_back(16'hBEEF);
        rv0 = rv_count;
        applyStimulus(16'hBEEF, FB, miso_w, extra, busy_pre, oe_pre);
        repeat (2 * HALF) @(negedge clk);
        checkOutput("recover_miso", 32'(miso_w), 32'h1FFE);
        checkOutput("recover_rx_valid_count", 32'(rv_count - rv0), 32'd1);
        checkOutput("recover_cur_channel", 32'(cur_channel), 32'd5);
        checkOutput("recover_rx_data", 32'(rx_data), 32'hBEEF);

        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so a stuck run still ends with a visible failure
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
